// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one multi-cycle divider among NUM_REQ requesters.
// It handles zero-divisor bypass, a watchdog timeout and a shared result bus with one-hot strobes.
module divider_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 11,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_REQ-1:0] req_valid_in,
  input  logic [WIDTH-1:0]   req_dividend_in [NUM_REQ],
  input  logic [WIDTH-1:0]   req_divisor_in  [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_out,
  output logic [NUM_REQ-1:0] resp_valid_out,
  output logic [WIDTH-1:0]   resp_quotient_out,
  output logic [WIDTH-1:0]   resp_remainder_out,
  output logic               resp_error_out,
  output logic [WIDTH-1:0]   div_dividend_out,
  output logic [WIDTH-1:0]   div_divisor_out,
  output logic               div_valid_out,
  input  logic [WIDTH-1:0]   div_quotient_in,
  input  logic [WIDTH-1:0]   div_remainder_in,
  input  logic               div_valid_in,
  input  logic               div_error_in,
  output logic               busy_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW:0]   NUM_EXT  = (PW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t             state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [PW-1:0]      grant_r;
  logic [WIDTH-1:0]   dividend_r;
  logic [WIDTH-1:0]   divisor_r;
  logic [TW-1:0]      timer_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   rem_r;
  logic               err_r;
  logic [NUM_REQ-1:0] resp_valid_r;
  logic               div_valid_r;

  logic               found_s;
  logic [PW-1:0]      pick_s;
  logic [PW:0]        sum_s;
  logic [PW-1:0]      idx_s;
  logic [NUM_REQ-1:0] ready_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin search: first pending requester at or after rr_ptr, wrapping explicitly.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s = {1'b0, rr_ptr_r} + (PW + 1)'(i);
      idx_s = (sum_s >= NUM_EXT) ? PW'(sum_s - NUM_EXT) : PW'(sum_s);
      if (!found_s && req_valid_in[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
        pick_s  = pick_s;
      end
    end
  end

  // Accept pulse: must follow the live request so a withdrawn request is never granted.
  always_comb begin
    if (rst_n_in && (state_r == S_IDLE) && found_s) begin
      ready_s = onehot(pick_s);
    end else begin
      ready_s = '0;
    end
  end

  // Main control FSM with registered divider handshake and result bus.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= S_IDLE;
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      dividend_r   <= '0;
      divisor_r    <= '0;
      timer_r      <= '0;
      quot_r       <= '0;
      rem_r        <= '0;
      err_r        <= 1'b0;
      resp_valid_r <= '0;
      div_valid_r  <= 1'b0;
    end else begin
      div_valid_r  <= 1'b0;
      resp_valid_r <= '0;
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            grant_r    <= pick_s;
            dividend_r <= req_dividend_in[pick_s];
            divisor_r  <= req_divisor_in[pick_s];
            // A zero divisor never reaches the divider; answer immediately.
            if (req_divisor_in[pick_s] == '0) begin
              quot_r       <= '1;
              rem_r        <= req_dividend_in[pick_s];
              err_r        <= 1'b1;
              resp_valid_r <= onehot(pick_s);
              state_r      <= S_RESPOND;
            end else begin
              div_valid_r <= 1'b1;
              state_r     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          timer_r <= '0;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (div_valid_in) begin
            quot_r       <= div_quotient_in;
            rem_r        <= div_remainder_in;
            err_r        <= div_error_in;
            resp_valid_r <= onehot(grant_r);
            state_r      <= S_RESPOND;
          end else if (timer_r == TMR_LAST) begin
            quot_r       <= '0;
            rem_r        <= '0;
            err_r        <= 1'b1;
            resp_valid_r <= onehot(grant_r);
            state_r      <= S_RESPOND;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_RESPOND: begin
          rr_ptr_r <= (grant_r == LAST_IDX) ? '0 : grant_r + PW'(1);
          state_r  <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign req_ready_out      = ready_s;
  assign resp_valid_out     = resp_valid_r;
  assign resp_quotient_out  = quot_r;
  assign resp_remainder_out = rem_r;
  assign resp_error_out     = err_r;
  assign div_dividend_out   = dividend_r;
  assign div_divisor_out    = divisor_r;
  assign div_valid_out      = div_valid_r;
  assign busy_out           = (state_r != S_IDLE);

endmodule
